axi_arbiter: RTL and testbench

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter_pkg.sv | 29 ++
 rtl/arb_rr2.sv | 43 ++++
 rtl/axi_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arbiter_pkg.sv
// ============================================================================
// Module : axi_arbiter_pkg
// Brief  : Shared types and default widths for the two-master AXI arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ============================================================================
// Module : arb_rr2
// Brief  : Two-way grant selector with round-robin pointer; fixed priority
//          (master 0 wins) when ARB_FIXED_PRIO_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_rr2
  import axi_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;

`ifdef ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, en};
  assign gnt_idx  = ~req[0];
`else
  logic r_ptr;

  // Pointed-to master wins if requesting; otherwise the other one.
  assign gnt_idx = req[r_ptr] ? r_ptr : ~r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (en && gnt_valid) begin
      r_ptr <= ~gnt_idx;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/axi_arbiter.sv
// ============================================================================
// Module : axi_arbiter
// Brief  : Two-master to one-slave AXI arbiter, one transaction at a time.
//          Define ARB_FIXED_PRIO_EN for fixed master-0 priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_arbiter
  import axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [7:0]          m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  input  logic                m0_wlast,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  output logic [ID_W-1:0]     m0_bid,
  input  logic                m0_bready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  input  logic                m1_wlast,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  output logic [ID_W-1:0]     m1_bid,
  input  logic                m1_bready,
  // shared slave
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  input  logic [ID_W-1:0]     s_bid,
  output logic                s_bready
);

  state_t     r_state;
  logic       r_owner;
  logic [1:0] w_req;
  logic       w_gnt_valid;
  logic       w_gnt_idx;
  logic       w_win_rd;
  logic       w_rd_done;
  logic       w_wr_done;

  assign w_req     = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};
  assign w_win_rd  = w_gnt_idx ? m1_arvalid : m0_arvalid;
  assign w_rd_done = s_rvalid & s_rlast & (r_owner ? m1_rready : m0_rready);
  assign w_wr_done = s_bvalid & (r_owner ? m1_bready : m0_bready);

  arb_rr2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (w_req),
    .en        (r_state == ST_IDLE),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_gnt_valid) begin
          r_owner <= w_gnt_idx;
          r_state <= w_win_rd ? ST_RD : ST_WR;
        end
        ST_RD:   if (w_rd_done) r_state <= ST_IDLE;
        ST_WR:   if (w_wr_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Payload fields follow the owner unconditionally; only handshakes are gated.
  assign s_araddr  = r_owner ? m1_araddr  : m0_araddr;
  assign s_arid    = r_owner ? m1_arid    : m0_arid;
  assign s_arlen   = r_owner ? m1_arlen   : m0_arlen;
  assign s_arsize  = r_owner ? m1_arsize  : m0_arsize;
  assign s_arburst = r_owner ? m1_arburst : m0_arburst;
  assign s_awaddr  = r_owner ? m1_awaddr  : m0_awaddr;
  assign s_awid    = r_owner ? m1_awid    : m0_awid;
  assign s_awlen   = r_owner ? m1_awlen   : m0_awlen;
  assign s_awsize  = r_owner ? m1_awsize  : m0_awsize;
  assign s_awburst = r_owner ? m1_awburst : m0_awburst;
  assign s_wdata   = r_owner ? m1_wdata   : m0_wdata;
  assign s_wstrb   = r_owner ? m1_wstrb   : m0_wstrb;
  assign s_wlast   = r_owner ? m1_wlast   : m0_wlast;

  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m0_bresp = s_bresp;
  assign m0_bid   = s_bid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_bresp = s_bresp;
  assign m1_bid   = s_bid;

  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (r_state)
      ST_RD: begin
        s_arvalid = r_owner ? m1_arvalid : m0_arvalid;
        s_rready  = r_owner ? m1_rready  : m0_rready;
        if (r_owner) begin
          m1_arready = s_arready;
          m1_rvalid  = s_rvalid;
        end else begin
          m0_arready = s_arready;
          m0_rvalid  = s_rvalid;
        end
      end
      ST_WR: begin
        s_awvalid = r_owner ? m1_awvalid : m0_awvalid;
        s_wvalid  = r_owner ? m1_wvalid  : m0_wvalid;
        s_bready  = r_owner ? m1_bready  : m0_bready;
        if (r_owner) begin
          m1_awready = s_awready;
          m1_wready  = s_wready;
          m1_bvalid  = s_bvalid;
        end else begin
          m0_awready = s_awready;
          m0_wready  = s_wready;
          m0_bvalid  = s_bvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_arbiter.sv
// ============================================================================
// Module : tb_axi_arbiter
// Brief  : Directed self-checking bench for axi_arbiter (vector table plus
//          hand-written multi-cycle sequences).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_arbiter;
  import axi_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam logic [AW-1:0] M0_AR = 32'h1000_0000;
  localparam logic [AW-1:0] M1_AR = 32'h2000_0000;
  localparam logic [AW-1:0] M0_AW = 32'h1000_0040;
  localparam logic [AW-1:0] M1_AW = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst;

  logic [AW-1:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, s_araddr, s_awaddr;
  logic m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid;
  logic [IW-1:0] m0_arid, m1_arid, m0_awid, m1_awid, m0_rid, m1_rid, m0_bid, m1_bid;
  logic [7:0] m0_arlen, m1_arlen, m0_awlen, m1_awlen, s_arlen, s_awlen;
  logic [2:0] m0_arsize, m1_arsize, m0_awsize, m1_awsize, s_arsize, s_awsize;
  logic [1:0] m0_arburst, m1_arburst, m0_awburst, m1_awburst, s_arburst, s_awburst;
  logic m0_arready, m1_arready, m0_awready, m1_awready, m0_wready, m1_wready;
  logic [DW-1:0] m0_rdata, m1_rdata, m0_wdata, m1_wdata, s_rdata, s_wdata;
  logic [1:0] m0_rresp, m1_rresp, m0_bresp, m1_bresp, s_rresp, s_bresp;
  logic m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic m0_wvalid, m1_wvalid, m0_wlast, m1_wlast;
  logic m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [IW-1:0] s_arid, s_awid, s_rid, s_bid;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;

  axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
    .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
    .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wlast(m0_wlast),
    .m0_wready(m0_wready), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bid(m0_bid),
    .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
    .m1_rid(m1_rid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bid(m1_bid),
    .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bid(s_bid),
    .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {s_arvalid, s_awvalid, s_wvalid, m0_arready, m1_arready,
  //  m0_rvalid, m1_rvalid, m0_bvalid, m1_bvalid, owner-is-m1}
  function automatic logic [9:0] obs();
    return {s_arvalid, s_awvalid, s_wvalid, m0_arready, m1_arready,
            m0_rvalid, m1_rvalid, m0_bvalid, m1_bvalid, (s_araddr == M1_AR)};
  endfunction

  typedef struct {
    logic [3:0] req;  // {m1_aw, m1_ar, m0_aw, m0_ar}
    logic [2:0] sin;  // {s_bvalid, s_rlast, s_rvalid}
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[18];
  logic exp_own;

  initial begin
    vecs[0]  = '{4'b0000, 3'b000, 10'b0000000000};
    vecs[1]  = '{4'b0101, 3'b000, 10'b0000000000};
    vecs[2]  = '{4'b0101, 3'b000, 10'b1001000000};
    vecs[3]  = '{4'b0100, 3'b001, 10'b0001010000};
    vecs[4]  = '{4'b0100, 3'b011, 10'b0001010000};
    vecs[5]  = '{4'b0100, 3'b000, 10'b0000000000};
    vecs[6]  = '{4'b0100, 3'b000, 10'b1000100001};
    vecs[7]  = '{4'b0000, 3'b011, 10'b0000101001};
    vecs[8]  = '{4'b0101, 3'b000, 10'b0000000001};
    vecs[9]  = '{4'b0100, 3'b000, 10'b0001000000};
    vecs[10] = '{4'b0100, 3'b011, 10'b0001010000};
    vecs[11] = '{4'b0011, 3'b000, 10'b0000000000};
    vecs[12] = '{4'b0010, 3'b000, 10'b0001000000};
    vecs[13] = '{4'b0010, 3'b011, 10'b0001010000};
    vecs[14] = '{4'b0010, 3'b000, 10'b0000000000};
    vecs[15] = '{4'b0010, 3'b000, 10'b0110000000};
    vecs[16] = '{4'b0000, 3'b100, 10'b0010000100};
    vecs[17] = '{4'b0000, 3'b111, 10'b0000000000};

    rst = 1'b1;
    m0_araddr = M0_AR; m1_araddr = M1_AR; m0_awaddr = M0_AW; m1_awaddr = M1_AW;
    m0_arid = 4'h1; m1_arid = 4'h2; m0_awid = 4'h3; m1_awid = 4'h4;
    m0_arlen = 8'd0; m1_arlen = 8'd0; m0_awlen = 8'd0; m1_awlen = 8'd0;
    m0_arsize = 3'd2; m1_arsize = 3'd2; m0_awsize = 3'd2; m1_awsize = 3'd2;
    m0_arburst = 2'b01; m1_arburst = 2'b01; m0_awburst = 2'b01; m1_awburst = 2'b01;
    m0_wdata = 32'h0000_00A0; m1_wdata = 32'h0000_00A1; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
    m0_wvalid = 1'b1; m1_wvalid = 1'b1; m0_wlast = 1'b1; m1_wlast = 1'b1;
    m0_rready = 1'b1; m1_rready = 1'b1; m0_bready = 1'b1; m1_bready = 1'b1;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    s_rdata = 32'hDEAD_BEEF; s_rresp = RESP_OKAY; s_rid = 4'h1; s_bresp = RESP_OKAY; s_bid = 4'h3;
    {m1_awvalid, m1_arvalid, m0_awvalid, m0_arvalid} = 4'b1111;
    {s_bvalid, s_rlast, s_rvalid} = 3'b111;

    // Outputs held quiet during reset even with every request active
    @(negedge clk); #1;
    check("reset_quiet", {54'd0, obs()}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    {m1_awvalid, m1_arvalid, m0_awvalid, m0_arvalid} = 4'b0000;
    {s_bvalid, s_rlast, s_rvalid} = 3'b000;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      {m1_awvalid, m1_arvalid, m0_awvalid, m0_arvalid} = vecs[i].req;
      {s_bvalid, s_rlast, s_rvalid} = vecs[i].sin;
      #1;
      check($sformatf("vec%0d", i), {54'd0, obs()}, {54'd0, vecs[i].exp});
      if (i == 4) check("rdata_pass", {32'd0, m0_rdata}, 64'hDEAD_BEEF);
    end

    // m1 write to 0x02000000 answered with SLVERR
    @(negedge clk);
    {s_bvalid, s_rlast, s_rvalid} = 3'b000;
    m1_awvalid = 1'b1;
    #1 check("wr_err_idle_m0b", {63'd0, m0_bvalid}, 64'd0);
    @(negedge clk); #1;
    check("wr_err_awaddr", {32'd0, s_awaddr}, {32'd0, M1_AW});
    check("wr_err_awvalid", {63'd0, s_awvalid}, 64'd1);
    @(negedge clk);
    m1_awvalid = 1'b0; s_bvalid = 1'b1; s_bresp = RESP_SLVERR; s_bid = 4'h9;
    #1;
    check("wr_err_m1_bvalid", {63'd0, m1_bvalid}, 64'd1);
    check("wr_err_m1_bresp", {62'd0, m1_bresp}, 64'd2);
    check("wr_err_m1_bid", {60'd0, m1_bid}, 64'h9);
    check("wr_err_m0_bvalid", {63'd0, m0_bvalid}, 64'd0);
    @(negedge clk);
    s_bvalid = 1'b0; s_bresp = RESP_OKAY;
    #1 check("wr_err_done_bvalid", {62'd0, m1_bvalid, m0_bvalid}, 64'd0);

    // Slow slave: m1 waits 15 cycles behind m0 without being accepted
    @(negedge clk);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_rresp = RESP_EXOKAY;
    #1 check("slow_idle_m1_arready", {63'd0, m1_arready}, 64'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 1) m0_arvalid = 1'b0;
      #1 check($sformatf("slow_hold%0d", i), {62'd0, m1_arready, m0_arready}, 64'd1);
    end
    @(negedge clk);
    s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    check("slow_m0_rvalid", {63'd0, m0_rvalid}, 64'd1);
    check("slow_m0_rresp", {62'd0, m0_rresp}, 64'd1);
    check("slow_m1_rvalid", {63'd0, m1_rvalid}, 64'd0);
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1 check("slow_gap_m1_arready", {63'd0, m1_arready}, 64'd0);
    @(negedge clk); #1;
    check("slow_m1_granted", {63'd0, m1_arready}, 64'd1);
    check("slow_m1_araddr", {32'd0, s_araddr}, {32'd0, M1_AR});
    @(negedge clk);
    m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
    #1 check("slow_m1_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd2);
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = RESP_OKAY;

    // Reset during a write with a pending response
    m0_awvalid = 1'b1;
    @(negedge clk); #1;
    check("rst_wr_awvalid", {63'd0, s_awvalid}, 64'd1);
    @(negedge clk);
    m0_awvalid = 1'b0; s_bvalid = 1'b1; m0_bready = 1'b0;
    #1 check("rst_pre_bvalid", {63'd0, m0_bvalid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_bvalid", {62'd0, m1_bvalid, m0_bvalid}, 64'd0);
    check("rst_wvalid", {62'd0, s_wvalid, s_bready}, 64'd0);
    @(negedge clk);
    rst = 1'b0; s_bvalid = 1'b0; m0_bready = 1'b1;
    @(negedge clk);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    @(negedge clk); #1;
    check("rst_next_grant_m0", {32'd0, s_araddr}, {32'd0, M0_AR});
    check("rst_next_arready", {62'd0, m1_arready, m0_arready}, 64'd1);
    @(negedge clk);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;

    // Both masters issuing reads back to back
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      s_rvalid = 1'b0; s_rlast = 1'b0;
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      #1 check($sformatf("cont%0d_gap", t), {62'd0, m1_arready, m0_arready}, 64'd0);
      @(negedge clk); #1;
`ifdef ARB_FIXED_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = (t % 2 == 0);
`endif
      check($sformatf("cont%0d_owner", t), {63'd0, s_araddr == M1_AR}, {63'd0, exp_own});
      check($sformatf("cont%0d_arready", t), {62'd0, m1_arready, m0_arready},
            exp_own ? 64'd2 : 64'd1);
      s_rvalid = 1'b1; s_rlast = 1'b1;
    end
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
